// File: rtl/cordic_mag_phase_if.sv
//------------------------------------------------------------------------------
// Module      : cordic_mag_phase_if
// Description : Streaming bundle for the CORDIC magnitude/phase stage.
//               The producer side drives the (Re, Im) sample and its valid
//               flag. The consumer side receives Mag, Phase and out_valid.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface cordic_mag_phase_if #(
  parameter int total_bits = 12
);
  logic                         in_valid;
  logic signed [total_bits-1:0] Re;
  logic signed [total_bits-1:0] Im;
  logic                         out_valid;
  logic        [total_bits-1:0] Mag;
  logic        [total_bits-1:0] Phase;

  modport master (output in_valid, Re, Im, input out_valid, Mag, Phase);
  modport slave  (input in_valid, Re, Im, output out_valid, Mag, Phase);
endinterface

`default_nettype wire

// File: rtl/cordic_mag_phase.sv
//------------------------------------------------------------------------------
// Module      : cordic_mag_phase
// Description : Pipelined CORDIC vectoring core. It turns an analytic-signal
//               sample (Re, Im) into envelope magnitude and binary-angle
//               phase. The core accepts one sample per clock and has a fixed
//               latency of ITER+2 clocks. The valid flag travels with the data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cordic_mag_phase #(
  parameter int total_bits = 12,
  parameter int ITER       = 10
) (
  input wire               clock,
  input wire               reset,
  cordic_mag_phase_if.slave bus
);

  // X/Y carry headroom for the CORDIC gain (~1.647) and for negating -2^(N-1).
  // Z has 4 guard bits below the output LSB and wraps modulo a full circle.
  localparam int          c_XW   = total_bits + 3;
  localparam int          c_ZW   = total_bits + 4;
  localparam int          c_PW   = c_XW + 11;
  localparam logic [10:0] c_GAIN = 11'd1244;   // 0.60725 * 2^11
  localparam logic [10:0] c_HALF = 11'd1024;   // rounding offset for the >>11

  // Micro-rotation angles are computed at elaboration. A full circle equals
  // 2^c_ZW. atan(x) comes from its Taylor series, which converges fast for x <= 1/2.
  function automatic logic [ITER*c_ZW-1:0] angle_table();
    logic [ITER*c_ZW-1:0] t;
    real x, term, sum;
    t = '0;
    for (int i = 0; i < ITER; i++) begin
      x = 1.0 / (2.0 ** i);
      if (i == 0) begin
        sum = 0.7853981633974483;
      end else begin
        sum  = 0.0;
        term = x;
        for (int k = 0; k < 40; k++) begin
          sum  = sum + (((k % 2) == 1) ? -term : term) / real'(2 * k + 1);
          term = term * x * x;
        end
      end
      t[i*c_ZW +: c_ZW] = c_ZW'(longint'(sum * (2.0 ** c_ZW) / 6.283185307179586));
    end
    return t;
  endfunction

  localparam logic [ITER*c_ZW-1:0] c_ANGLES = angle_table();

  // Index 0 holds the pre-rotation stage. Index i+1 holds micro-rotation i.
  logic signed [c_XW-1:0] r_x [ITER+1];
  logic signed [c_XW-1:0] r_y [ITER+1];
  logic        [c_ZW-1:0] r_z [ITER+1];
  logic        [ITER:0]   r_v;
  logic        [ITER:0]   r_zero;

  logic                   r_out_valid;
  logic [total_bits-1:0]  r_mag;
  logic [total_bits-1:0]  r_phase;

  logic signed [c_XW-1:0] w_re_ext;
  logic signed [c_XW-1:0] w_im_ext;
  logic        [c_XW-1:0] w_x_pos;
  logic        [c_PW-1:0] w_prod;
  logic        [c_XW-1:0] w_mag_wide;
  logic [total_bits-1:0]  w_mag;
  logic [total_bits-1:0]  w_phase;
  logic                   w_unused;

  // Sign-extend before negating so that Re = -2^(N-1) maps to an exact +2^(N-1).
  assign w_re_ext = {{3{bus.Re[total_bits-1]}}, bus.Re};
  assign w_im_ext = {{3{bus.Im[total_bits-1]}}, bus.Im};

  // The data path advances every clock. Valid and zero flags ride alongside.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= ITER; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_z[i] <= '0;
      end
      r_v    <= '0;
      r_zero <= '0;
    end else begin
      // Fold the left half-plane onto the right half-plane, starting at 180 degrees.
      r_v[0]    <= bus.in_valid;
      r_zero[0] <= (bus.Re == '0) && (bus.Im == '0);
      if (bus.Re[total_bits-1]) begin
        r_x[0] <= -w_re_ext;
        r_y[0] <= -w_im_ext;
        r_z[0] <= {1'b1, {(c_ZW-1){1'b0}}};
      end else begin
        r_x[0] <= w_re_ext;
        r_y[0] <= w_im_ext;
        r_z[0] <= '0;
      end
      // Each stage rotates toward Y = 0 and accumulates the rotation applied.
      for (int i = 0; i < ITER; i++) begin
        r_v[i+1]    <= r_v[i];
        r_zero[i+1] <= r_zero[i];
        if (!r_y[i][c_XW-1]) begin
          r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] + c_ANGLES[i*c_ZW +: c_ZW];
        end else begin
          r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] - c_ANGLES[i*c_ZW +: c_ZW];
        end
      end
    end
  end

  // Gain compensation. The final X is non-negative by construction, and the
  // clamp only guards against misuse.
  assign w_x_pos    = r_x[ITER][c_XW-1] ? '0 : $unsigned(r_x[ITER]);
  assign w_prod     = c_PW'(w_x_pos) * c_PW'(c_GAIN) + c_PW'(c_HALF);
  assign w_mag_wide = w_prod[c_PW-1:11];
  assign w_mag      = (|w_mag_wide[c_XW-1:total_bits]) ? '1 : w_mag_wide[total_bits-1:0];
  assign w_phase    = r_z[ITER][c_ZW-1:4] + total_bits'(r_z[ITER][3]);

  // The output registers update only for valid samples. Between samples they hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_phase     <= '0;
    end else begin
      r_out_valid <= r_v[ITER];
      if (r_v[ITER]) begin
        r_mag   <= r_zero[ITER] ? '0 : w_mag;
        r_phase <= r_zero[ITER] ? '0 : w_phase;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.Mag       = r_mag;
  assign bus.Phase     = r_phase;

  // The final Y residual and the sub-LSB bits are intentionally discarded.
  assign w_unused = ^{r_y[ITER], r_z[ITER][2:0], w_prod[10:0]};

endmodule

`default_nettype wire
